// File: rtl/clock_bcd_display.sv
// clock_bcd_display
//   Converts binary hour/minute into four BCD digits by repeated subtraction
//   of 10. It also scans the registered digits onto a multiplexed 4-digit
//   7-segment display.
//
// Parameters
//   SCAN_DIV        clk cycles each digit stays lit (>= 2)
//   SEG_ACTIVE_LOW  1: seg/anode active-low, 0: active-high
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   hour, minute    binary time request (legal 0-23 / 0-59)
//   load            conversion request, honoured only while idle
//   busy            high whenever a conversion is in flight
//   done, err       one-cycle completion pulse, err marks an out-of-range request
//   H_out1..M_out0  BCD digits, updated together on completion
//   anode, seg      display drive, seg order {g,f,e,d,c,b,a}
//
// state  | meaning
// IDLE   | waiting for load
// CONV_H | subtracting 10 from hour, counting hour tens
// CONV_M | subtracting 10 from minute, counting minute tens
// DONE   | one-cycle result/err pulse, back to IDLE next edge
module clock_bcd_display #(
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hour,
  input  logic [5:0] minute,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] H_out1,
  output logic [3:0] H_out0,
  output logic [3:0] M_out1,
  output logic [3:0] M_out0,
  output logic [3:0] anode,
  output logic [6:0] seg
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_H = 2'd1,
    CONV_M = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  work_h, work_m;
  logic [1:0]  h_tens;
  logic [2:0]  m_tens;
  logic        req_bad;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    scan_idx;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_hi;
  logic [3:0]    anode_hi;

  // The range check is registered with the request; CONV_H then routes a bad
  // request straight to DONE, so the error pulse appears one cycle after the
  // load edge and the work registers are never disturbed by illegal values.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONV_H;
      CONV_H:  begin
        if (req_bad)             state_nxt = DONE;
        else if (work_h < 6'd10) state_nxt = CONV_M;
      end
      CONV_M:  if (work_m < 6'd10) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Once CONV_H exits, work_h already holds the hour units, so it is copied
  // straight to H_out0 when the minute conversion finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_h  <= '0;
      work_m  <= '0;
      h_tens  <= '0;
      m_tens  <= '0;
      req_bad <= 1'b0;
      H_out1  <= '0;
      H_out0  <= '0;
      M_out1  <= '0;
      M_out0  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            work_h  <= hour;
            work_m  <= minute;
            h_tens  <= '0;
            m_tens  <= '0;
            req_bad <= (hour > 6'd23) || (minute > 6'd59);
          end
        end
        CONV_H: begin
          if (!req_bad && work_h >= 6'd10) begin
            work_h <= work_h - 6'd10;
            h_tens <= h_tens + 2'd1;
          end
        end
        CONV_M: begin
          if (work_m >= 6'd10) begin
            work_m <= work_m - 6'd10;
            m_tens <= m_tens + 3'd1;
          end else begin
            H_out1 <= h_tens;
            H_out0 <= work_h[3:0];
            M_out1 <= {1'b0, m_tens};
            M_out0 <= work_m[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = (state == DONE) && req_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    cur_digit = M_out0;
    case (scan_idx)
      2'd0: cur_digit = M_out0;
      2'd1: cur_digit = M_out1;
      2'd2: cur_digit = H_out0;
      2'd3: cur_digit = {2'b00, H_out1};
      default: cur_digit = M_out0;
    endcase
  end

  always_comb begin
    seg_hi = 7'b0000000;
    case (cur_digit)
      4'd0: seg_hi = 7'b0111111;
      4'd1: seg_hi = 7'b0000110;
      4'd2: seg_hi = 7'b1011011;
      4'd3: seg_hi = 7'b1001111;
      4'd4: seg_hi = 7'b1100110;
      4'd5: seg_hi = 7'b1101101;
      4'd6: seg_hi = 7'b1111101;
      4'd7: seg_hi = 7'b0000111;
      4'd8: seg_hi = 7'b1111111;
      4'd9: seg_hi = 7'b1101111;
      default: seg_hi = 7'b0000000;
    endcase
  end

  assign anode_hi = 4'b0001 << scan_idx;
  assign anode    = (SEG_ACTIVE_LOW != 0) ? ~anode_hi : anode_hi;
  assign seg      = (SEG_ACTIVE_LOW != 0) ? ~seg_hi   : seg_hi;

endmodule

// File: tb/tb_clock_bcd_display.sv
module tb_clock_bcd_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] hour, minute;
  logic       load;
  logic       busy, done, err;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0;
  logic [3:0] anode;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  int n_edges;
  int model_h = 0, model_m = 0;

  always #5 clk = ~clk;

  clock_bcd_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .hour(hour), .minute(minute), .load(load),
    .busy(busy), .done(done), .err(err),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .anode(anode), .seg(seg)
  );

  // Edges since reset release; the displayed digit follows (edges / 4) mod 4.
  always @(posedge clk or posedge reset) begin
    if (reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;
  end

  function automatic logic [6:0] seg_pat(input int d);
    case (d)
      0: return 7'b0111111;  1: return 7'b0000110;
      2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [13:0] model_digits();
    return {2'(model_h / 10), 4'(model_h % 10), 4'(model_m / 10), 4'(model_m % 10)};
  endfunction

  // Drives one request and observes the following 25 cycles.
  task automatic issue(input logic [5:0] h, input logic [5:0] m, input int glitch_c,
                       output int lat, output int ndone, output bit saw_err,
                       output bit err_stray, output bit busy_ok);
    lat = -1; ndone = 0; saw_err = 0; err_stray = 0; busy_ok = 1;
    @(negedge clk);
    hour = h; minute = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (done) begin
        ndone++;
        if (lat < 0) lat = c;
        if (err) saw_err = 1;
      end else if (err) begin
        err_stray = 1;
      end
      if (lat < 0 || c == lat) begin
        if (!busy) busy_ok = 0;
      end else if (c == lat + 1 && busy) begin
        busy_ok = 0;
      end
      if (c == glitch_c) begin
        hour = 6'd1; minute = 6'd1; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy=%b done=%b err=%b required 0 0 0", busy, done, err);
    end
    checks++;
    if ({H_out1, H_out0, M_out1, M_out0} !== 14'd0) begin
      errors++; $display("FAIL reset_digits got %h required 0", {H_out1, H_out0, M_out1, M_out0});
    end
    checks++;
    if (anode !== 4'b1110 || seg !== 7'b1000000) begin
      errors++; $display("FAIL reset_display anode=%b seg=%b required 1110 1000000", anode, seg);
    end
  endtask

  task automatic test_valid(input int h, input int m, input string name);
    int lat, nd, exp_lat; bit se, es, bo;
    issue(6'(h), 6'(m), -1, lat, nd, se, es, bo);
    model_h = h; model_m = m;
    exp_lat = h / 10 + 1 + m / 10 + 1;
    checks++;
    if (lat != exp_lat || nd != 1) begin
      errors++; $display("FAIL %s_latency %0d:%0d got lat=%0d pulses=%0d required lat=%0d pulses=1", name, h, m, lat, nd, exp_lat);
    end
    checks++;
    if (se || es) begin
      errors++; $display("FAIL %s_err %0d:%0d err raised on valid request", name, h, m);
    end
    checks++;
    if (!bo) begin
      errors++; $display("FAIL %s_busy %0d:%0d busy window wrong, required high through done", name, h, m);
    end
    checks++;
    if ({H_out1, H_out0, M_out1, M_out0} !== model_digits()) begin
      errors++; $display("FAIL %s_digits got %h required %h", name, {H_out1, H_out0, M_out1, M_out0}, model_digits());
    end
  endtask

  task automatic test_worst();  test_valid(23, 59, "worst"); endtask

  task automatic test_best();
    test_valid(0, 0, "best");
    test_valid(12, 5, "twelve05");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      test_valid(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), "random");
  endtask

  task automatic test_busy_ignore();
    int lat, nd; bit se, es, bo;
    issue(6'd23, 6'd59, 3, lat, nd, se, es, bo);
    model_h = 23; model_m = 59;
    checks++;
    if (nd != 1 || lat != 9) begin
      errors++; $display("FAIL busy_ignore got pulses=%0d lat=%0d required pulses=1 lat=9", nd, lat);
    end
    checks++;
    if ({H_out1, H_out0, M_out1, M_out0} !== model_digits()) begin
      errors++; $display("FAIL busy_ignore_digits got %h required %h", {H_out1, H_out0, M_out1, M_out0}, model_digits());
    end
  endtask

  task automatic test_error();
    int lat, nd, hh, mm; bit se, es, bo;
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      begin hh = 24; mm = 0; end
      else if (i[0])   begin hh = int'($urandom_range(24, 63)); mm = int'($urandom_range(0, 63)); end
      else             begin hh = int'($urandom_range(0, 23));  mm = int'($urandom_range(60, 63)); end
      issue(6'(hh), 6'(mm), -1, lat, nd, se, es, bo);
      checks++;
      if (lat != 1 || nd != 1 || !se || es) begin
        errors++; $display("FAIL error_pulse %0d:%0d got lat=%0d pulses=%0d err=%b stray=%b required lat=1 pulses=1 err=1", hh, mm, lat, nd, se, es);
      end
      checks++;
      if (!bo) begin
        errors++; $display("FAIL error_busy %0d:%0d busy window wrong", hh, mm);
      end
      checks++;
      if ({H_out1, H_out0, M_out1, M_out0} !== model_digits()) begin
        errors++; $display("FAIL error_digits got %h required %h (unchanged)", {H_out1, H_out0, M_out1, M_out0}, model_digits());
      end
    end
  endtask

  task automatic test_scan();
    int idx, dig;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int digs[4];
    int steps;
    test_valid(23, 59, "scan_setup");
    digs[0] = model_m % 10; digs[1] = model_m / 10; digs[2] = model_h % 10; digs[3] = model_h / 10;
    steps = 0;
    for (int c = 0; c < 24; c++) begin
      idx = (n_edges / 4) % 4;
      dig = digs[idx];
      exp_an = ~(4'b0001 << idx);
      exp_seg = ~seg_pat(dig);
      checks++;
      if (anode !== exp_an || seg !== exp_seg) begin
        errors++; $display("FAIL scan edge=%0d got anode=%b seg=%b required anode=%b seg=%b", n_edges, anode, seg, exp_an, exp_seg);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nd; bit se, es, bo, seen;
    @(negedge clk);
    hour = 6'd23; minute = 6'd59; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {H_out1, H_out0, M_out1, M_out0} !== 14'd0) begin
      errors++; $display("FAIL reset_mid busy=%b done=%b digits=%h required 0 0 0", busy, done, {H_out1, H_out0, M_out1, M_out0});
    end
    checks++;
    if (anode !== 4'b1110 || seg !== 7'b1000000) begin
      errors++; $display("FAIL reset_mid_display anode=%b seg=%b required 1110 1000000", anode, seg);
    end
    model_h = 0; model_m = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_mid_quiet done/busy seen after reset, required none");
    end
    test_valid(7, 30, "after_reset");
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; hour = '0; minute = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_worst();
    test_best();
    test_random();
    test_busy_ignore();
    test_error();
    test_scan();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
